dp_eq_pipe: RTL and testbench
=============================

DP_EQ_PIPE -- requirements
Module: dp_eq_pipe

Interface
REQ-001 Parameter DATAWIDTH, default 64: width of every data port and internal datapath signal; legal values 8 to 64.
REQ-002 Parameter CNTWIDTH, default 16: width of match_cnt.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Rst  input  1  reset, asynchronous assert, active-low, deasserted synchronously to Clk by the system.
REQ-005 a, b, c, zero  input  DATAWIDTH  operand set; zero is the compare reference.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block accepts the operand set this cycle.
REQ-008 z  output  DATAWIDTH  result.
REQ-009 gEQz  output  1  compare flag travelling with z.
REQ-010 out_valid  output  1  z/gEQz valid.
REQ-011 out_ready  input  1  consumer accepts z this cycle.
REQ-012 match_cnt  output  CNTWIDTH  saturating count of delivered results with gEQz=1 (present only under DP_MATCH_CNT_EN).

Function
REQ-013 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-014 Stage 1 registers e = a + b, f = a + c, and zero; sums wrap modulo 2^DATAWIDTH, carries discarded.
REQ-015 Stage 2 registers g = e - f (wrap modulo 2^DATAWIDTH) and forwards e and zero.
REQ-016 Stage 3 registers gEQz = (g == zero) and z = gEQz ? e : g.
REQ-017 Each stage has a valid bit; a stage loads when empty or when its contents move on in the same cycle.
REQ-018 in_ready = !v1 || (stage 1 advances this cycle); readiness is combinational from out_ready back through the stages, with no combinational in_valid-to-out_valid path.
REQ-019 Latency: an operand set accepted in cycle N appears with out_valid=1 in cycle N+3 when out_ready is held at 1.
REQ-020 Throughput: one result per cycle with out_ready=1; zero bubbles inserted.
REQ-021 Backpressure: with out_ready=0, z, gEQz and out_valid hold stable; the pipeline fills to 3 entries, then in_ready=0.
REQ-022 Ordering: results leave in acceptance order; no entry is dropped or duplicated.
REQ-023 Simultaneous load and drain of a full pipeline proceeds without a bubble.
REQ-024 A stage whose valid bit is 0 holds its data registers unchanged, so idle cycles cause no data toggling.

Reset
REQ-025 While Rst=0: all valid bits=0, z=0, gEQz=0, out_valid=0, match_cnt=0, and internal data registers=0.
REQ-026 in_ready=1 in the first cycle after reset release.
REQ-027 Reset asserted mid-operation discards every in-flight entry immediately; no partial result is output after release.

Configuration
REQ-028 Macro DP_MATCH_CNT_EN defined: match_cnt exists and increments by 1 on each out transfer with gEQz=1, saturating at 2^CNTWIDTH-1.
REQ-029 Macro DP_MATCH_CNT_EN undefined: the match_cnt port and counter logic are absent; all other behaviour is identical.

Structure
REQ-030 Package dp_pkg holds DP_DEFAULT_DATAWIDTH=64, DP_DEFAULT_CNTWIDTH=16 and the pipeline depth constant DP_PIPE_DEPTH=3.
REQ-031 Sub-module dp_pipe_slice, instantiated once per stage, implements the valid bit, load enable and data register for a parametrised payload width.

Verification
REQ-032 Single op: a=5, b=3, c=1, zero=6 -> e=8, f=6, g=2; 2!=6 -> z=2, gEQz=0 at cycle N+3.
REQ-033 Match: a=10, b=7, c=4, zero=3 -> g=3=zero -> z=17, gEQz=1; match_cnt increments 0 to 1 (macro defined).
REQ-034 Wrap: DATAWIDTH=8, a=0xFF, b=0x02, c=0x10, zero=0 -> e=0x01, f=0x0F, g=0xF2 -> z=0xF2, gEQz=0.
REQ-035 Backpressure: stream 5 ops with out_ready=0 -> in_ready drops after 3 accepts, z holds; then out_ready=1 -> all 5 results emerge in order with no loss.
REQ-036 Reset mid-stream: Rst=0 with 2 entries in flight -> out_valid=0 immediately, match_cnt=0, and no stale result after release.
REQ-037 Counter saturation: CNTWIDTH=2, 5 matching results -> match_cnt sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/dp_pkg.sv
// dp_pkg: shared constants for the dp_eq_pipe compare pipeline
package dp_pkg;

    localparam int DP_DEFAULT_DATAWIDTH = 64;
    localparam int DP_DEFAULT_CNTWIDTH  = 16;
    localparam int DP_PIPE_DEPTH        = 3;

endpackage

// File: rtl/dp_eq_pipe_if.sv
// dp_eq_pipe_if: operand/result handshake bundle of dp_eq_pipe
interface dp_eq_pipe_if
    import dp_pkg::*;
#(
    parameter int DATAWIDTH = DP_DEFAULT_DATAWIDTH
);

    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [DATAWIDTH-1:0] c;
    logic [DATAWIDTH-1:0] zero;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] z;
    logic                 gEQz;
    logic                 out_valid;
    logic                 out_ready;

    // producer/consumer side
    modport master (
        output a, b, c, zero, in_valid, out_ready,
        input  in_ready, z, gEQz, out_valid
    );

    // pipeline side
    modport slave (
        input  a, b, c, zero, in_valid, out_ready,
        output in_ready, z, gEQz, out_valid
    );

endinterface

// File: rtl/dp_pipe_slice.sv
// dp_pipe_slice: one elastic pipeline stage (valid bit + payload register)
module dp_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic         v_q, v_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    assign in_ready_o  = !v_q || out_ready_i;
    assign out_valid_o = v_q;
    assign out_data_o  = data_q;

    // load only on an accepted entry so an empty stage keeps its data still
    always_comb begin
        load   = in_valid_i && in_ready_o;
        v_d    = in_ready_o ? in_valid_i : v_q;
        data_d = load ? in_data_i : data_q;
    end

    // stage state register, cleared by asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/dp_eq_pipe.sv
// dp_eq_pipe: 3-stage z = (g==zero) ? e : g pipeline; DP_MATCH_CNT_EN adds match_cnt
module dp_eq_pipe
    import dp_pkg::*;
#(
    parameter int DATAWIDTH = DP_DEFAULT_DATAWIDTH
`ifdef DP_MATCH_CNT_EN
    ,
    parameter int CNTWIDTH  = DP_DEFAULT_CNTWIDTH
`endif
) (
    input  logic                Clk,
    input  logic                Rst,
    dp_eq_pipe_if.slave         bus
`ifdef DP_MATCH_CNT_EN
    ,
    output logic [CNTWIDTH-1:0] match_cnt
`endif
);

    localparam int W = DATAWIDTH;

    logic [3*W-1:0] s1_d, s1_q;
    logic [3*W-1:0] s2_d, s2_q;
    logic [W:0]     s3_d, s3_q;
    logic           v1, v2, v3;
    logic           r1, r2, r3;
    logic [W-1:0]   e_d, f_d, e1, f1, zero1;
    logic [W-1:0]   g_d, g2, e2, zero2;
    logic           eq;

    // per-stage combinational datapath; sums and difference wrap at W bits
    always_comb begin
        e_d   = bus.a + bus.b;
        f_d   = bus.a + bus.c;
        s1_d  = {e_d, f_d, bus.zero};
        e1    = s1_q[3*W-1:2*W];
        f1    = s1_q[2*W-1:W];
        zero1 = s1_q[W-1:0];
        g_d   = e1 - f1;
        s2_d  = {g_d, e1, zero1};
        g2    = s2_q[3*W-1:2*W];
        e2    = s2_q[2*W-1:W];
        zero2 = s2_q[W-1:0];
        eq    = g2 == zero2;
        s3_d  = {eq, eq ? e2 : g2};
    end

    dp_pipe_slice #(.W(3*W)) u_s1 (
        .clk_i(Clk), .rst_ni(Rst),
        .in_valid_i(bus.in_valid), .in_data_i(s1_d), .in_ready_o(r1),
        .out_valid_o(v1), .out_data_o(s1_q), .out_ready_i(r2)
    );

    dp_pipe_slice #(.W(3*W)) u_s2 (
        .clk_i(Clk), .rst_ni(Rst),
        .in_valid_i(v1), .in_data_i(s2_d), .in_ready_o(r2),
        .out_valid_o(v2), .out_data_o(s2_q), .out_ready_i(r3)
    );

    dp_pipe_slice #(.W(W+1)) u_s3 (
        .clk_i(Clk), .rst_ni(Rst),
        .in_valid_i(v2), .in_data_i(s3_d), .in_ready_o(r3),
        .out_valid_o(v3), .out_data_o(s3_q), .out_ready_i(bus.out_ready)
    );

    assign bus.in_ready  = r1;
    assign bus.out_valid = v3;
    assign bus.gEQz      = s3_q[W];
    assign bus.z         = s3_q[W-1:0];

`ifdef DP_MATCH_CNT_EN
    logic [CNTWIDTH-1:0] cnt_q, cnt_d;

    // count delivered matches, sticking at all-ones
    always_comb begin
        cnt_d = (v3 && bus.out_ready && s3_q[W] && cnt_q != '1) ? cnt_q + CNTWIDTH'(1) : cnt_q;
    end

    // match counter register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dp_eq_pipe.sv
// tb_dp_eq_pipe: scoreboard bench for dp_eq_pipe (8-bit datapath, 2-bit counter)
module tb_dp_eq_pipe;

    localparam int W  = 8;
    localparam int CW = 2;

    typedef struct {
        logic [W-1:0] z;
        logic         eq;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dp_eq_pipe_if #(.DATAWIDTH(W)) bus ();

`ifdef DP_MATCH_CNT_EN
    logic [CW-1:0] match_cnt;
    dp_eq_pipe #(.DATAWIDTH(W), .CNTWIDTH(CW)) dut (
        .Clk(clk), .Rst(rst_n), .bus(bus), .match_cnt(match_cnt)
    );
`else
    dp_eq_pipe #(.DATAWIDTH(W)) dut (
        .Clk(clk), .Rst(rst_n), .bus(bus)
    );
`endif

    exp_t         q[$];
    exp_t         x;
    int           total = 0;
    int           bad = 0;
    int           exp_cnt = 0;
    int           last_stall;
    bit           prev_hold = 0;
    logic [W-1:0] prev_z;
    logic         prev_eq;
    bit           rand_done = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // reference: plain modular arithmetic straight from the rules
    function automatic exp_t model(input logic [W-1:0] a, b, c, zero);
        int   m;
        int   e;
        int   f;
        int   g;
        exp_t r;
        m    = 1 << W;
        e    = (int'(a) + int'(b)) % m;
        f    = (int'(a) + int'(c)) % m;
        g    = ((e - f) % m + m) % m;
        r.eq = (g == int'(zero));
        r.z  = r.eq ? W'(e) : W'(g);
        return r;
    endfunction

    task automatic send(input logic [W-1:0] a, b, c, zero, input exp_t e);
        bit acc;
        acc = 0;
        last_stall = 0;
        bus.a = a;
        bus.b = b;
        bus.c = c;
        bus.zero = zero;
        bus.in_valid = 1'b1;
        while (!acc && last_stall < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) q.push_back(e);
            @(posedge clk);
            #1;
            if (!acc) last_stall++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", last_stall);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand(input bit force_match);
        logic [W-1:0] a, b, c, zero;
        a = W'($urandom);
        b = W'($urandom);
        c = W'($urandom);
        zero = force_match ? b - c : W'($urandom);
        send(a, b, c, zero, model(a, b, c, zero));
    endtask

    // monitor: pops the scoreboard on every output transfer
    always @(negedge clk) begin
        if (!rst_n) prev_hold = 0;
        else begin
            if (prev_hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_z", bus.z, prev_z);
                chk("hold_geqz", bus.gEQz, prev_eq);
            end
`ifdef DP_MATCH_CNT_EN
            chk("match_cnt", match_cnt, exp_cnt);
`endif
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got z=%0h with nothing pending", bus.z);
                end else begin
                    x = q.pop_front();
                    chk("z", bus.z, x.z);
                    chk("geqz", bus.gEQz, x.eq);
                    if (x.eq && exp_cnt < (1 << CW) - 1) exp_cnt++;
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_z = bus.z;
            prev_eq = bus.gEQz;
        end
    end

    initial begin
        int lat;
        int stalls;
        int n;
        bus.a = '0;
        bus.b = '0;
        bus.c = '0;
        bus.zero = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_z", bus.z, 0);
        chk("rst_geqz", bus.gEQz, 0);
`ifdef DP_MATCH_CNT_EN
        chk("rst_cnt", match_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", bus.in_ready, 1);
        @(posedge clk);
        #1;
        send(8'd5, 8'd3, 8'd1, 8'd6, '{z: 8'h02, eq: 1'b0});
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 3);
        repeat (3) @(posedge clk);
        #1;
        send(8'd10, 8'd7, 8'd4, 8'd3, '{z: 8'd17, eq: 1'b1});
        repeat (5) @(posedge clk);
        #1;
        send(8'hFF, 8'h02, 8'h10, 8'h00, '{z: 8'hF2, eq: 1'b0});
        repeat (5) @(posedge clk);
        #1;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send_rand(i[0]);
            stalls += last_stall;
        end
        chk("no_bubble", stalls, 0);
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand(i == 1);
        fork
            send_rand(1'b0);
            begin
                repeat (4) @(negedge clk) chk("full_in_ready", bus.in_ready, 0);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        send_rand(1'b1);
        repeat (6) @(posedge clk);
        #1;
        send_rand(1'b1);
        send_rand(1'b1);
        rst_n = 1'b0;
        q.delete();
        exp_cnt = 0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_z", bus.z, 0);
`ifdef DP_MATCH_CNT_EN
        chk("midrst_cnt", match_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk) chk("no_stale", bus.out_valid, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(W'(i * 7), 8'd5, 8'd2, 8'd3, '{z: W'(i * 7 + 5), eq: 1'b1});
        repeat (6) @(posedge clk);
        #1;
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = $urandom_range(0, 3) != 0;
                end
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send_rand($urandom_range(0, 1) == 1);
                end
                rand_done = 1;
            end
        join
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
